board_mem_slave: RTL and testbench



---
 rtl/board_mem_slave.sv | 77 +++++++
 tb/tb_board_mem_slave.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/board_mem_slave.sv
// Avalon-MM board store: one signed 8-bit piece code per word address, with
// programmable waitrequest stalls and a fixed-latency pipelined read return.
module board_mem_slave #(
    parameter int DEPTH        = 1024,
    parameter int WAIT_CYCLES  = 1,
    parameter int READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        slave_waitrequest,
    input  logic [31:0] slave_address,
    input  logic        slave_read,
    input  logic        slave_write,
    input  logic [31:0] slave_writedata,
    output logic [31:0] slave_readdata,
    output logic        slave_readdatavalid,
    output logic        err
);

    localparam int         AW     = $clog2(DEPTH);
    localparam logic [3:0] WAIT_C = 4'(WAIT_CYCLES);

    // Handshake: a command (read or write) is held by the master until the
    // cycle waitrequest is low; the rising edge ending that cycle accepts it.
    logic [7:0]              mem [DEPTH];
    logic [3:0]              stall_cnt;
    logic                    cmd;
    logic                    accept;
    logic                    rd_accept;
    logic                    in_range;
    logic [AW-1:0]           idx;
    logic [31:0]             rd_value;
    logic [READ_LATENCY-1:0] vld_pipe;
    logic [31:0]             data_pipe [READ_LATENCY];
    logic                    unused_wdata;

    assign cmd               = slave_read | slave_write;
    assign accept            = cmd && (stall_cnt == WAIT_C);
    assign rd_accept         = accept && slave_read;
    assign slave_waitrequest = ~accept;
    assign in_range          = slave_address < 32'(DEPTH);
    assign idx               = slave_address[AW-1:0];
    assign rd_value          = in_range ? {{24{mem[idx][7]}}, mem[idx]} : 32'hFFFF_FFFF;
    assign unused_wdata      = ^slave_writedata[31:8];

    assign slave_readdatavalid = vld_pipe[READ_LATENCY-1];
    assign slave_readdata      = data_pipe[READ_LATENCY-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            vld_pipe  <= '0;
            err       <= 1'b0;
            for (int i = 0; i < READ_LATENCY; i++) data_pipe[i] <= '0;
        end else begin
            if (!cmd || accept) stall_cnt <= '0;
            else                stall_cnt <= stall_cnt + 4'd1;

            // Idle stages carry zero so readdata is 0 whenever valid is low.
            vld_pipe[0]  <= rd_accept;
            data_pipe[0] <= rd_accept ? rd_value : '0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                data_pipe[i] <= data_pipe[i-1];
            end

            if (accept && (!in_range || (slave_read && slave_write))) err <= 1'b1;
        end
    end

    // Storage is deliberately not reset; a simultaneous read+write acts as a read only.
    always_ff @(posedge clk) begin
        if (accept && slave_write && !slave_read && in_range)
            mem[idx] <= slave_writedata[7:0];
    end

endmodule

// File: tb/tb_board_mem_slave.sv
// Bench for board_mem_slave: three instances with different stall settings,
// a timed scoreboard on read responses and per-cycle waitrequest checks.
module tb_board_mem_slave;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;
    localparam int WC [3] = '{1, 0, 3};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd   [3];
    logic        wr   [3];
    logic [31:0] addr [3];
    logic [31:0] wd   [3];
    logic        wreq [3];
    logic [31:0] rdata[3];
    logic        rdv  [3];
    logic        errf [3];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [31:0] exp_q [$];
    int          exp_t [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        board_mem_slave #(
            .DEPTH(DEPTH), .WAIT_CYCLES(WC[g]), .READ_LATENCY(LAT)
        ) u_dut (
            .clk(clk), .rst(rst),
            .slave_waitrequest(wreq[g]),
            .slave_address(addr[g]),
            .slave_read(rd[g]),
            .slave_write(wr[g]),
            .slave_writedata(wd[g]),
            .slave_readdata(rdata[g]),
            .slave_readdatavalid(rdv[g]),
            .err(errf[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the accept
    // edge with the command still driven, so consecutive calls go back-to-back.
    task automatic do_cmd(input int g, input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_rd, input bit push);
        rd[g] = r; wr[g] = w; addr[g] = a; wd[g] = d;
        for (int k = 0; k <= WC[g]; k++) begin
            #1;
            check("waitreq", {31'd0, wreq[g]}, (k == WC[g]) ? 32'd0 : 32'd1);
            if (k == WC[g] && push) begin
                exp_q.push_back(exp_rd);
                exp_t.push_back(cyc + 1 + LAT);
            end
            @(negedge clk);
        end
    endtask

    task automatic idle(input int g, input int n);
        rd[g] = 1'b0; wr[g] = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (rdv[g]) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    check("rdata", rdata[g], exp_q.pop_front());
                    check("rvalid_time", cyc + 1, exp_t.pop_front());
                end
            end else if (rdata[g] !== 32'd0) begin
                check("rdata_idle", rdata[g], 32'd0);
            end
        end
    end

    initial begin
        for (int g = 0; g < 3; g++) begin
            rd[g] = 1'b0; wr[g] = 1'b0; addr[g] = '0; wd[g] = '0;
        end
        repeat (3) @(negedge clk);
        #1;
        check("rst_waitreq", {31'd0, wreq[0]}, 32'd1);
        check("rst_rvalid", {31'd0, rdv[0]}, 32'd0);
        check("rst_rdata", rdata[0], 32'd0);
        check("rst_err", {31'd0, errf[0]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Preload the zero-wait instance.
        do_cmd(1, 0, 1, 0,  32'h05, 0, 0);
        do_cmd(1, 0, 1, 1,  32'h00, 0, 0);
        do_cmd(1, 0, 1, 2,  32'hFD, 0, 0);
        do_cmd(1, 0, 1, 10, 32'h02, 0, 0);
        idle(1, 1);

        // One-stall write then read of a negative piece code.
        do_cmd(0, 0, 1, 70, 32'h0000_00FA, 0, 0);
        do_cmd(0, 1, 0, 70, 0, 32'hFFFF_FFFA, 1);
        idle(0, LAT + 2);

        // Back-to-back pipelined reads.
        do_cmd(1, 1, 0, 0, 0, 32'h0000_0005, 1);
        do_cmd(1, 1, 0, 1, 0, 32'h0000_0000, 1);
        do_cmd(1, 1, 0, 2, 0, 32'hFFFF_FFFD, 1);
        idle(1, LAT + 2);
        check("pipe_drained", exp_q.size(), 32'd0);

        // Withdrawn command on the three-stall instance.
        rd[2] = 1'b1; addr[2] = 3;
        #1 check("withdraw_waitreq", {31'd0, wreq[2]}, 32'd1);
        @(negedge clk);
        idle(2, 4);
        check("withdraw_err", {31'd0, errf[2]}, 32'd0);
        do_cmd(2, 0, 1, 3, 32'h7F, 0, 0);
        do_cmd(2, 1, 0, 3, 0, 32'h0000_007F, 1);
        idle(2, LAT + 2);

        // Out-of-range read, then err must stick across a good access.
        do_cmd(1, 1, 0, DEPTH + 5, 0, 32'hFFFF_FFFF, 1);
        idle(1, LAT + 1);
        check("oor_err", {31'd0, errf[1]}, 32'd1);
        do_cmd(1, 1, 0, 0, 0, 32'h0000_0005, 1);
        idle(1, LAT + 2);
        check("err_sticky", {31'd0, errf[1]}, 32'd1);

        // Simultaneous read and write acts as a read only.
        do_cmd(0, 0, 1, 10, 32'h02, 0, 0);
        idle(0, 1);
        check("pre_both_err", {31'd0, errf[0]}, 32'd0);
        do_cmd(0, 1, 1, 10, 32'h07, 32'h0000_0002, 1);
        idle(0, LAT + 2);
        check("both_err", {31'd0, errf[0]}, 32'd1);
        do_cmd(0, 1, 0, 10, 0, 32'h0000_0002, 1);
        idle(0, LAT + 2);

        // Reset one cycle after a read accept discards the response.
        do_cmd(0, 1, 0, 70, 0, 0, 0);
        rd[0] = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_mid_rvalid", {31'd0, rdv[0]}, 32'd0);
        check("rst_mid_waitreq", {31'd0, wreq[0]}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        idle(0, LAT + 3);
        check("post_rst_err", {31'd0, errf[0]}, 32'd0);
        do_cmd(0, 1, 0, 70, 0, 32'hFFFF_FFFA, 1);
        idle(0, LAT + 2);

        check("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d", total);
        $fatal(1, "timeout");
    end

endmodule
